// File: rtl/sbmips_pkg.sv
// Shared encodings for the single-step MIPS demo: opcodes, functs,
// debug LED source selectors and the fixed program ROM image.
package sbmips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    LED_REG  = 3'd0,
    LED_PC   = 3'd1,
    LED_IMEM = 3'd2,
    LED_DMEM = 3'd3,
    LED_STEP = 3'd4
  } led_src_e;

  localparam logic [31:0] PROG_ROM [32] = '{
    32'h24010000, 32'h2402000A, 32'h00220821, 32'h2442FFFF,
    32'h1440FFFD, 32'hAC010000, 32'h08000006, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two async operand reads, one debug read (low 12 bits),
// one write port; $0 always reads zero and ignores writes.
module regfile (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  input  logic [4:0]  i_raddr_dbg,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b,
  output logic [11:0] o_rdata_dbg
);

  logic [31:0] r_regs [32];

  // Register array with async clear and single write port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a   = (i_raddr_a == 5'd0) ? 32'h0 : r_regs[i_raddr_a];
  assign o_rdata_b   = (i_raddr_b == 5'd0) ? 32'h0 : r_regs[i_raddr_b];
  assign o_rdata_dbg = (i_raddr_dbg == 5'd0) ? 12'h0 : r_regs[i_raddr_dbg][11:0];

endmodule

// File: rtl/top.sv
// Single-step MIPS-subset demo core: one instruction per synchronized button
// press, with a debug mux exposing 12-bit slices of state on the LEDs.
module top
  import sbmips_pkg::*;
(
  input  logic        gclk,
  input  logic        rst,
  input  logic        btn,
  input  logic [7:0]  led_sel,
  output logic [11:0] led
);

  logic        r_sync1, r_sync2, r_sync3;
  logic        w_step;
  logic [31:0] r_pc;
  logic [11:0] r_stepcnt;
  logic [31:0] r_dmem [32];

  logic [31:0] w_instr;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_dm_idx;
  logic [15:0] w_imm;
  logic [25:0] w_target;
  logic [31:0] w_rs_val, w_rt_val, w_simm, w_zimm, w_pc4, w_lw_data;
  logic [11:0] w_rf_dbg;

  logic        w_rf_we, w_dm_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata, w_next_pc;
  logic [11:0] w_led;

  // Button synchronizer plus edge-detect stage
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_step   = r_sync2 & ~r_sync3;

  assign w_instr  = PROG_ROM[r_pc[6:2]];
  assign w_op     = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_shamt  = w_instr[10:6];
  assign w_funct  = w_instr[5:0];
  assign w_imm    = w_instr[15:0];
  assign w_target = w_instr[25:0];

  assign w_simm    = {{16{w_imm[15]}}, w_imm};
  assign w_zimm    = {16'h0, w_imm};
  assign w_pc4     = r_pc + 32'd4;
  // Word index only; the low two address bits are deliberately dropped
  assign w_dm_idx  = 5'((w_rs_val + w_simm) >> 2);
  assign w_lw_data = r_dmem[w_dm_idx];

  regfile u_regfile (
    .i_clk       (gclk),
    .i_rst_n     (rst),
    .i_we        (w_rf_we & w_step),
    .i_waddr     (w_rf_waddr),
    .i_wdata     (w_rf_wdata),
    .i_raddr_a   (w_rs),
    .i_raddr_b   (w_rt),
    .i_raddr_dbg (led_sel[4:0]),
    .o_rdata_a   (w_rs_val),
    .o_rdata_b   (w_rt_val),
    .o_rdata_dbg (w_rf_dbg)
  );

  // Decode and execute; unknown encodings fall through as nop
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = 5'd0;
    w_rf_wdata = 32'h0;
    w_dm_we    = 1'b0;
    w_next_pc  = w_pc4;
    case (w_op)
      OP_RTYPE: begin
        w_rf_waddr = w_rd;
        case (w_funct)
          FN_ADDU: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val + w_rt_val; end
          FN_SUBU: begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val - w_rt_val; end
          FN_AND:  begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val & w_rt_val; end
          FN_OR:   begin w_rf_we = 1'b1; w_rf_wdata = w_rs_val | w_rt_val; end
          FN_SLT:  begin
            w_rf_we    = 1'b1;
            w_rf_wdata = {31'h0, ($signed(w_rs_val) < $signed(w_rt_val))};
          end
          FN_SLL:  begin w_rf_we = 1'b1; w_rf_wdata = w_rt_val << w_shamt; end
          default: w_rf_we = 1'b0;
        endcase
      end
      OP_ADDIU: begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = w_rs_val + w_simm; end
      OP_ANDI:  begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = w_rs_val & w_zimm; end
      OP_ORI:   begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = w_rs_val | w_zimm; end
      OP_LUI:   begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = {w_imm, 16'h0}; end
      OP_LW:    begin w_rf_we = 1'b1; w_rf_waddr = w_rt; w_rf_wdata = w_lw_data; end
      OP_SW:    w_dm_we = 1'b1;
      OP_BEQ: begin
        if (w_rs_val == w_rt_val) w_next_pc = w_pc4 + {w_simm[29:0], 2'b00};
        else                      w_next_pc = w_pc4;
      end
      OP_BNE: begin
        if (w_rs_val != w_rt_val) w_next_pc = w_pc4 + {w_simm[29:0], 2'b00};
        else                      w_next_pc = w_pc4;
      end
      OP_J:     w_next_pc = {w_pc4[31:28], w_target, 2'b00};
      default:  w_next_pc = w_pc4;
    endcase
  end

  // PC and step counter advance only on a step pulse
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      r_pc      <= 32'h0;
      r_stepcnt <= 12'h0;
    end else if (w_step) begin
      r_pc      <= w_next_pc;
      r_stepcnt <= r_stepcnt + 12'd1;
    end
  end

  // Data memory, written by sw during a step
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_dmem[i] <= 32'h0;
    end else if (w_step && w_dm_we) begin
      r_dmem[w_dm_idx] <= w_rt_val;
    end
  end

  // Debug LED source mux
  always_comb begin
    w_led = 12'h0;
    case (led_src_e'(led_sel[7:5]))
      LED_REG:  w_led = w_rf_dbg;
      LED_PC:   w_led = r_pc[11:0];
      LED_IMEM: w_led = w_instr[11:0];
      LED_DMEM: w_led = r_dmem[led_sel[4:0]][11:0];
      LED_STEP: w_led = r_stepcnt;
      default:  w_led = 12'h0;
    endcase
  end

  assign led = w_led;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed button/reset scenarios plus random
// presses, resets and LED selections compared against an instruction-level model.
module tb_top;

  logic        gclk;
  logic        rst;
  logic        btn;
  logic [7:0]  led_sel;
  logic [11:0] led;

  int n_total;
  int n_bad;

  logic [31:0] prog  [32];
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [32];
  logic [31:0] m_pc;
  logic [11:0] m_cnt;

  top dut (
    .gclk    (gclk),
    .rst     (rst),
    .btn     (btn),
    .led_sel (led_sel),
    .led     (led)
  );

  initial gclk = 1'b0;
  always #10 gclk = ~gclk;

  task automatic chk_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%03h expected 0x%03h (led_sel=0x%02h)", tag, got, exp, led_sel);
    end
  endtask

  function automatic logic [31:0] sx16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'h0;
      m_mem[i] = 32'h0;
    end
    m_pc  = 32'h0;
    m_cnt = 12'h0;
  endtask

  task automatic model_wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_reg[r] = v;
  endtask

  // Architectural effect of one instruction, straight from the ISA rules
  task automatic model_step();
    logic [31:0] ins, a, b, si, npc, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    ins = prog[m_pc[6:2]];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
    rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
    a = m_reg[rs]; b = m_reg[rt]; si = sx16(ins[15:0]);
    ea = a + si;
    npc = m_pc + 32'd4;
    case (op)
      6'h00: case (fn)
        6'h21: model_wr(rd, a + b);
        6'h23: model_wr(rd, a - b);
        6'h24: model_wr(rd, a & b);
        6'h25: model_wr(rd, a | b);
        6'h2A: model_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'h00: model_wr(rd, b << sh);
        default: ;
      endcase
      6'h09: model_wr(rt, a + si);
      6'h0C: model_wr(rt, a & {16'h0, ins[15:0]});
      6'h0D: model_wr(rt, a | {16'h0, ins[15:0]});
      6'h0F: model_wr(rt, {ins[15:0], 16'h0});
      6'h23: model_wr(rt, m_mem[ea[6:2]]);
      6'h2B: m_mem[ea[6:2]] = b;
      6'h04: if (a == b) npc = npc + (si << 2);
      6'h05: if (a != b) npc = npc + (si << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      default: ;
    endcase
    m_pc  = npc;
    m_cnt = m_cnt + 12'd1;
  endtask

  function automatic logic [11:0] model_led(input logic [7:0] sel);
    logic [31:0] w;
    case (sel[7:5])
      3'd0: w = m_reg[sel[4:0]];
      3'd1: w = m_pc;
      3'd2: w = prog[m_pc[6:2]];
      3'd3: w = m_mem[sel[4:0]];
      3'd4: w = {20'h0, m_cnt};
      default: w = 32'h0;
    endcase
    return w[11:0];
  endfunction

  task automatic sample(input logic [7:0] sel, input string tag, input logic [11:0] exp);
    led_sel = sel;
    #1;
    chk_val(tag, led, exp);
  endtask

  // One press of given high/low widths; counts as one step once complete
  task automatic press(input int hi, input int lo, input bit counts);
    @(negedge gclk);
    btn = 1'b1;
    repeat (hi) @(negedge gclk);
    btn = 1'b0;
    repeat (lo) @(negedge gclk);
    if (counts) model_step();
  endtask

  // Half-cycle async reset pulse; LEDs must clear before the next gclk edge
  task automatic async_rst_chk();
    logic [4:0] idx;
    @(posedge gclk);
    #1 rst = 1'b0;
    model_reset();
    for (int s = 0; s < 8; s++) begin
      idx = 5'($urandom_range(0, 31));
      sample({3'(s), idx}, "rst_async", 12'h000);
    end
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] sel;
    n_total = 0;
    n_bad   = 0;
    prog[0] = 32'h24010000; prog[1] = 32'h2402000A; prog[2] = 32'h00220821;
    prog[3] = 32'h2442FFFF; prog[4] = 32'h1440FFFD; prog[5] = 32'hAC010000;
    prog[6] = 32'h08000006;
    for (int i = 7; i < 32; i++) prog[i] = 32'h0;
    model_reset();

    rst = 1'b0; btn = 1'b0; led_sel = 8'h00;
    repeat (3) @(negedge gclk);
    for (int i = 0; i < 10; i++) press(2, 2, 1'b0);
    for (int s = 0; s < 8; s++) begin
      sel = {3'(s), 5'($urandom_range(0, 31))};
      sample(sel, "in_reset", 12'h000);
    end
    sample(8'h20, "in_reset_pc", 12'h000);

    @(negedge gclk);
    rst = 1'b1;
    repeat (100) @(negedge gclk);
    sample(8'h20, "idle_pc", 12'h000);
    sample(8'h80, "idle_cnt", 12'h000);

    press(4, 4, 1'b1);
    press(4, 4, 1'b1);
    sample(8'h20, "two_pc", 12'h008);
    sample(8'h02, "two_r2", 12'h00A);
    sample(8'h80, "two_cnt", 12'h002);
    sample(8'h01, "two_r1", model_led(8'h01));

    for (int i = 0; i < 31; i++) press($urandom_range(2, 5), $urandom_range(2, 5), 1'b1);
    sample(8'h01, "loop_r1", 12'h037);
    sample(8'h60, "loop_mem0", 12'h037);
    sample(8'h20, "loop_pc", 12'h018);
    sample(8'h40, "loop_imem", 12'h006);
    for (int i = 0; i < 5; i++) press(3, 3, 1'b1);
    sample(8'h20, "jloop_pc", 12'h018);
    sample(8'h80, "jloop_cnt", 12'h026);

    for (int i = 0; i < 3; i++) press(3, 3, 1'b1);
    async_rst_chk();
    press(4, 4, 1'b1);
    sample(8'h20, "after_rst_pc", 12'h004);
    sample(8'h80, "after_rst_cnt", 12'h001);

    press(50, 4, 1'b1);
    sample(8'h80, "held_cnt", 12'h002);
    sample(8'h20, "held_pc", 12'h008);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 11) == 0) async_rst_chk();
      else press($urandom_range(2, 6), $urandom_range(2, 6), 1'b1);
      for (int k = 0; k < 3; k++) begin
        sel = 8'($urandom_range(0, 255));
        sample(sel, "rand", model_led(sel));
      end
      sample(8'h20, "rand_pc", model_led(8'h20));
      sample(8'h80, "rand_cnt", model_led(8'h80));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
